// File: rtl/xm_mem_pkg.sv
// Shared types for the memory-port arbiter: sequencer states, requester ids
// and the latched access descriptor.
package xm_mem_pkg;

  localparam int XM_WORD = 16;
  localparam int XM_ADDR = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } port_t;

  typedef struct packed {
    logic               rw;
    logic               byteOp;
    logic [XM_ADDR-1:0] adr;
    logic [XM_WORD-1:0] data;
  } mem_req_t;

  function automatic logic [1:0] port_onehot(port_t p);
    return (p == DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/xm_rr_arb2.sv
// Two-way round-robin arbiter; the grant is combinational and only issued
// while gntEn_i is high, and the last winner is remembered for tie-breaks.
module xm_rr_arb2
  import xm_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       gntEn_i,
  output logic [1:0] gnt_o,
  output port_t      winner_o
);

  port_t last_q, last_d;

  always_comb begin
    gnt_o    = 2'b00;
    winner_o = CPU;
    if (gntEn_i) begin
      unique case (req_i)
        2'b01:   winner_o = CPU;
        2'b10:   winner_o = DMA;
        // tie goes to whoever did not win last time
        2'b11:   winner_o = (last_q == DMA) ? CPU : DMA;
        default: winner_o = CPU;
      endcase
      if (|req_i) begin
        gnt_o = port_onehot(winner_o);
      end
    end
    last_d = last_q;
    if (|gnt_o) begin
      last_d = winner_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= DMA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/xm_mem_arbiter.sv
// Shares one memory port between the CPU and a DMA/debug requester: round-robin
// grant, latched request, IDLE/ACCESS/DONE sequencer and a per-access timeout.
//
//   state  | meaning
//   IDLE   | waiting for a request; grant issued here only
//   ACCESS | memory driven from the latch; waiting for memRdy_i or timeout
//   DONE   | owner's busy released, read data / error presented
module xm_mem_arbiter
  import xm_mem_pkg::*;
#(
  parameter int WORD    = XM_WORD,
  parameter int ADDR    = XM_ADDR,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            cpuEn_i,
  input  logic            cpuRW_i,
  input  logic            cpuByte_i,
  input  logic [ADDR-1:0] cpuAdr_i,
  input  logic [WORD-1:0] cpuData_i,
  output logic            cpuBusy_o,
  output logic [WORD-1:0] cpuData_o,
  output logic            cpuErr_o,

  input  logic            dmaEn_i,
  input  logic            dmaRW_i,
  input  logic            dmaByte_i,
  input  logic [ADDR-1:0] dmaAdr_i,
  input  logic [WORD-1:0] dmaData_i,
  output logic            dmaBusy_o,
  output logic [WORD-1:0] dmaData_o,
  output logic            dmaErr_o,

  output logic            memEn_o,
  output logic            memRW_o,
  output logic            memByte_o,
  output logic [ADDR-1:0] memAdr_o,
  output logic [WORD-1:0] memData_o,
  input  logic [WORD-1:0] memData_i,
  input  logic            memRdy_i,

  output logic [1:0]      gnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  mem_req_t        req_q, req_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [WORD-1:0] cpuData_q, cpuData_d;
  logic [WORD-1:0] dmaData_q, dmaData_d;
  logic            cpuErr_q, cpuErr_d;
  logic            dmaErr_q, dmaErr_d;

  mem_req_t   cpuReq, dmaReq;
  logic [1:0] arbGnt;
  port_t      arbWin;

  assign cpuReq = '{rw: cpuRW_i, byteOp: cpuByte_i, adr: cpuAdr_i, data: cpuData_i};
  assign dmaReq = '{rw: dmaRW_i, byteOp: dmaByte_i, adr: dmaAdr_i, data: dmaData_i};

  xm_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({dmaEn_i, cpuEn_i}),
    .gntEn_i  (state_q == IDLE),
    .gnt_o    (arbGnt),
    .winner_o (arbWin)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    gnt_d     = gnt_q;
    timer_d   = timer_q;
    cpuData_d = cpuData_q;
    dmaData_d = dmaData_q;
    cpuErr_d  = 1'b0;
    dmaErr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|arbGnt) begin
          gnt_d   = arbGnt;
          req_d   = (arbWin == DMA) ? dmaReq : cpuReq;
          timer_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        timer_d = timer_q + 1'b1;
        // a ready arriving on the last allowed cycle still completes normally
        if (memRdy_i) begin
          if (!req_q.rw) begin
            if (gnt_q[1]) dmaData_d = memData_i;
            else          cpuData_d = memData_i;
          end
          state_d = DONE;
        end else if (timer_q == TO_LAST) begin
          cpuErr_d = gnt_q[0];
          dmaErr_d = gnt_q[1];
          state_d  = DONE;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      gnt_q     <= 2'b00;
      timer_q   <= '0;
      cpuData_q <= '0;
      dmaData_q <= '0;
      cpuErr_q  <= 1'b0;
      dmaErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gnt_q     <= gnt_d;
      timer_q   <= timer_d;
      cpuData_q <= cpuData_d;
      dmaData_q <= dmaData_d;
      cpuErr_q  <= cpuErr_d;
      dmaErr_q  <= dmaErr_d;
    end
  end

  assign memEn_o   = (state_q == ACCESS);
  assign memRW_o   = req_q.rw;
  assign memByte_o = req_q.byteOp;
  assign memAdr_o  = req_q.adr;
  assign memData_o = req_q.data;
  assign gnt_o     = gnt_q;

  assign cpuData_o = cpuData_q;
  assign dmaData_o = dmaData_q;
  assign cpuErr_o  = cpuErr_q;
  assign dmaErr_o  = dmaErr_q;

  // busy deliberately depends only on the request level and the sequencer
  assign cpuBusy_o = cpuEn_i & ~((state_q == DONE) & gnt_q[0]);
  assign dmaBusy_o = dmaEn_i & ~((state_q == DONE) & gnt_q[1]);

endmodule
